// File: rtl/mole_spawner.sv
// mole_spawner
//   Initiator side of the mole start handshake. An LFSR supplies a random
//   starting hole and an interval timer paces the attempts. After each
//   interval the FSM scans for an empty hole, then raises that hole's start
//   line. The line stays high until the mole leaves the empty state (accepted)
//   or a hold timeout expires (aborted).
//
// Ports
//   animation_clk  in   frame clock, all logic on the rising edge
//   rst            in   synchronous active-high reset
//   game_en        in   1 = spawning enabled, 0 = drop back to IDLE
//   pause          in   1 = freeze FSM, timers and LFSR (outputs hold)
//   mole_states    in   2 bits per hole, hole i at [2i+1:2i], 2'b00 = empty
//   start          out  one-hot (or zero) start request per hole
//   active_count   out  registered count of non-empty holes
//   spawns_total   out  accepted spawns, saturating at 255
//   busy           out  high while the FSM is in PICK or HOLD
module mole_spawner #(
  parameter int          NUM_MOLES    = 4,
  parameter int          SPAWN_FRAMES = 12,
  parameter int          MAX_ACTIVE   = 2,
  parameter int          HOLD_TIMEOUT = 15,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                   animation_clk,
  input  logic                   rst,
  input  logic                   game_en,
  input  logic                   pause,
  input  logic [2*NUM_MOLES-1:0] mole_states,
  output logic [NUM_MOLES-1:0]   start,
  output logic [3:0]             active_count,
  output logic [7:0]             spawns_total,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, COUNT, PICK, HOLD} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] interval;
  logic [7:0] hold_cnt;
  logic [2:0] cand;
  logic [3:0] tries;

  // Occupancy is padded to 8 holes so a 3-bit candidate index always fits.
  logic [7:0] occ_pad;
  logic [3:0] occ_count;
  logic [7:0] onehot;
  logic [2:0] cand_seed;
  logic [2:0] cand_next;
  logic       lfsr_fb;

  always_comb begin
    // NOTE: every combinational signal gets a default first so no path infers a latch.
    occ_pad   = '0;
    occ_count = '0;
    for (int i = 0; i < NUM_MOLES; i++) occ_pad[i] = |mole_states[2*i +: 2];
    for (int i = 0; i < 8; i++) occ_count = occ_count + 4'(occ_pad[i]);
  end

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Random start hole: low three LFSR bits folded once into 0..NUM_MOLES-1.
  assign cand_seed = ({1'b0, lfsr[2:0]} >= 4'(NUM_MOLES)) ? lfsr[2:0] - 3'(NUM_MOLES)
                                                          : lfsr[2:0];
  assign cand_next = (cand == 3'(NUM_MOLES - 1)) ? 3'd0 : cand + 3'd1;
  assign onehot    = 8'd1 << cand;

  always_ff @(posedge animation_clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      interval     <= '0;
      hold_cnt     <= '0;
      cand         <= '0;
      tries        <= '0;
      start        <= '0;
      active_count <= '0;
      spawns_total <= '0;
      busy         <= 1'b0;
    end else begin
      // Occupancy count tracks the holes even while paused.
      active_count <= occ_count;

      if (!pause) begin
        lfsr <= {lfsr[6:0], lfsr_fb};

        if (!game_en) begin
          // Any pending request is abandoned and never counted.
          state    <= IDLE;
          start    <= '0;
          busy     <= 1'b0;
          interval <= '0;
          hold_cnt <= '0;
          tries    <= '0;
        end else begin
          case (state)
            IDLE: begin
              state    <= COUNT;
              interval <= 8'(SPAWN_FRAMES);
            end

            COUNT: begin
              interval <= interval - 8'd1;
              if (interval == 8'd1) begin
                state <= PICK;
                busy  <= 1'b1;
                cand  <= cand_seed;
                tries <= '0;
              end
            end

            PICK: begin
              // Limit uses the registered count; one hole examined per frame.
              if (active_count >= 4'(MAX_ACTIVE)) begin
                state    <= COUNT;
                busy     <= 1'b0;
                interval <= 8'(SPAWN_FRAMES);
              end else if (!occ_pad[cand]) begin
                state    <= HOLD;
                start    <= onehot[NUM_MOLES-1:0];
                hold_cnt <= '0;
              end else if (tries == 4'(NUM_MOLES - 1)) begin
                state    <= COUNT;
                busy     <= 1'b0;
                interval <= 8'(SPAWN_FRAMES);
              end else begin
                cand  <= cand_next;
                tries <= tries + 4'd1;
              end
            end

            HOLD: begin
              // Acceptance is tested first so it wins over a same-frame timeout.
              if (occ_pad[cand]) begin
                state    <= COUNT;
                start    <= '0;
                busy     <= 1'b0;
                interval <= 8'(SPAWN_FRAMES);
                if (spawns_total != 8'hFF) spawns_total <= spawns_total + 8'd1;
              end else if (hold_cnt == 8'(HOLD_TIMEOUT - 1)) begin
                state    <= COUNT;
                start    <= '0;
                busy     <= 1'b0;
                interval <= 8'(SPAWN_FRAMES);
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end

            default: begin
              state <= IDLE;
              start <= '0;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner
//   Self-checking bench for mole_spawner. Instance dut_a uses the default
//   parameters (MAX_ACTIVE=2); dut_b uses MAX_ACTIVE=4 for multi-hole scans.
//   Both share clock, reset and pause, so one LFSR model predicts both.
module tb_mole_spawner;

  localparam int         N    = 4;
  localparam int         SF   = 12;
  localparam int         HT   = 15;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, pause, game_en_a, game_en_b;
  logic [2*N-1:0] ms_a, ms_b;
  logic [N-1:0]   start_a, start_b;
  logic [3:0]     act_a, act_b;
  logic [7:0]     sp_a, sp_b;
  logic           busy_a, busy_b;

  mole_spawner #(.NUM_MOLES(N), .SPAWN_FRAMES(SF), .MAX_ACTIVE(2),
                 .HOLD_TIMEOUT(HT), .LFSR_SEED(SEED)) dut_a (
    .animation_clk(clk), .rst(rst), .game_en(game_en_a), .pause(pause),
    .mole_states(ms_a), .start(start_a), .active_count(act_a),
    .spawns_total(sp_a), .busy(busy_a));

  mole_spawner #(.NUM_MOLES(N), .SPAWN_FRAMES(SF), .MAX_ACTIVE(4),
                 .HOLD_TIMEOUT(HT), .LFSR_SEED(SEED)) dut_b (
    .animation_clk(clk), .rst(rst), .game_en(game_en_b), .pause(pause),
    .mole_states(ms_b), .start(start_b), .active_count(act_b),
    .spawns_total(sp_b), .busy(busy_b));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] lfsr_m;
  logic [3:0] sb_q[$];

  typedef struct {
    logic           pause;
    logic [2*N-1:0] ms;
    logic [3:0]     exp_act;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One rising edge; the LFSR model advances with the inputs seen at that edge.
  task automatic tick();
    logic [7:0] nxt;
    if (rst)        nxt = SEED;
    else if (pause) nxt = lfsr_m;
    else            nxt = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    @(posedge clk);
    #1;
    lfsr_m = nxt;
  endtask

  function automatic logic [N-1:0] occ_of(input logic [2*N-1:0] ms);
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) o[i] = (ms[2*i +: 2] != 2'b00);
    return o;
  endfunction

  function automatic logic [N-1:0] hot(input int h);
    logic [N-1:0] v;
    v = '0;
    if (h >= 0 && h < N) v[h] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] st(input bit sel);
    return sel ? start_b : start_a;
  endfunction

  function automatic logic bz(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Called right after an edge that put the DUT into COUNT with a fresh interval.
  // Runs through the interval and the PICK scan; returns the hole that should
  // now be held, or -1 when the attempt must fall back to COUNT.
  task automatic attempt(input bit sel, input string tag, output int hole);
    logic [7:0]   l;
    logic [N-1:0] occ;
    int           c, act, ma, examined;
    bit           ok;
    ma   = sel ? 4 : 2;
    hole = -1;
    ok   = 1'b1;
    for (int i = 0; i < SF - 1; i++) begin
      tick();
      if (st(sel) != '0 || bz(sel)) ok = 1'b0;
    end
    check({tag, "_count_quiet"}, 32'(ok), 32'd1);
    l = lfsr_m;
    tick();
    check({tag, "_pick_busy"}, 32'(bz(sel)), 32'd1);
    occ = occ_of(sel ? ms_b : ms_a);
    act = $countones(occ);
    c   = int'(l[2:0]);
    if (c >= N) c -= N;
    if (act >= ma) begin
      examined = 1;
    end else begin
      examined = N;
      for (int k = 0; k < N; k++)
        if (hole < 0 && !occ[(c + k) % N]) begin
          hole     = (c + k) % N;
          examined = k + 1;
        end
    end
    ok = 1'b1;
    for (int i = 0; i < examined - 1; i++) begin
      tick();
      if (st(sel) != '0 || !bz(sel)) ok = 1'b0;
    end
    check({tag, "_scan"}, 32'(ok), 32'd1);
    tick();
    check({tag, "_start"}, 32'(st(sel)), 32'(hot(hole)));
    check({tag, "_busy"}, 32'(bz(sel)), (hole >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   h, h2, h3, h4, hb, hx, exp_sp;
    bit   ok;
    logic [3:0] exp_act;

    vecs[0] = '{1'b0, 8'h01, 4'd1};
    vecs[1] = '{1'b0, 8'h0C, 4'd1};
    vecs[2] = '{1'b0, 8'h55, 4'd4};
    vecs[3] = '{1'b0, 8'hAA, 4'd4};
    vecs[4] = '{1'b0, 8'h80, 4'd1};
    vecs[5] = '{1'b0, 8'h36, 4'd3};
    vecs[6] = '{1'b1, 8'hC3, 4'd2};
    vecs[7] = '{1'b1, 8'h30, 4'd1};
    vecs[8] = '{1'b0, 8'h00, 4'd0};
    vecs[9] = '{1'b0, 8'h00, 4'd0};

    // Reset with occupied holes: everything must still read zero.
    rst = 1'b1; pause = 1'b0; game_en_a = 1'b0; game_en_b = 1'b0;
    ms_a = 8'h55; ms_b = '0;
    tick(); tick();
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_active", 32'(act_a), 32'd0);
    check("rst_spawns", 32'(sp_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);

    // Popcount vectors (IDLE), including paused rows.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pause = vecs[i].pause;
      ms_a  = vecs[i].ms;
      sb_q.push_back(vecs[i].exp_act);
      tick();
      exp_act = sb_q.pop_front();
      check("vec_active", 32'(act_a), 32'(exp_act));
      check("vec_idle", 32'({start_a, busy_a}), 32'd0);
    end
    pause = 1'b0;

    // First spawn from IDLE with all holes empty.
    game_en_a = 1'b1;
    tick();
    attempt(1'b0, "first", h);
    if (h < 0) h = 0;

    // Accepted after the line has been held 9 frames.
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start_a != hot(h)) ok = 1'b0;
    end
    check("accept_hold", 32'(ok), 32'd1);
    ms_a[2*h +: 2] = 2'b01;
    tick();
    check("accept_drop", 32'(start_a), 32'd0);
    check("accept_count", 32'(sp_a), 32'd1);
    check("accept_busy", 32'(busy_a), 32'd0);

    // Next attempt skips the now-occupied hole if picked; then never accepted.
    attempt(1'b0, "second", h2);
    ok = 1'b1;
    for (int i = 0; i < HT - 1; i++) begin
      tick();
      if (start_a != hot(h2)) ok = 1'b0;
    end
    check("timeout_hold", 32'(ok), 32'd1);
    tick();
    check("timeout_drop", 32'(start_a), 32'd0);
    check("timeout_count", 32'(sp_a), 32'd1);
    check("timeout_busy", 32'(busy_a), 32'd0);

    // Pause for 20 frames mid-HOLD: hold counter and LFSR freeze.
    attempt(1'b0, "third", h3);
    for (int i = 0; i < 5; i++) tick();
    pause = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_a != hot(h3) || !busy_a || sp_a != 8'd1) ok = 1'b0;
    end
    check("pause_hold", 32'(ok), 32'd1);
    pause = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < HT - 6; i++) begin
      tick();
      if (start_a != hot(h3)) ok = 1'b0;
    end
    check("pause_resume_hold", 32'(ok), 32'd1);
    tick();
    check("pause_timeout_drop", 32'(start_a), 32'd0);
    attempt(1'b0, "after_pause", h4);

    // game_en drop mid-HOLD: ignored while paused, honoured on the next free edge.
    for (int i = 0; i < 3; i++) tick();
    pause = 1'b1; game_en_a = 1'b0;
    tick();
    check("disable_paused", 32'(start_a), 32'(hot(h4)));
    pause = 1'b0;
    tick();
    check("disable_start", 32'(start_a), 32'd0);
    check("disable_busy", 32'(busy_a), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_a != '0 || busy_a) ok = 1'b0;
    end
    check("idle_stays", 32'(ok), 32'd1);
    check("disable_count", 32'(sp_a), 32'd1);

    // Two holes busy with MAX_ACTIVE=2: busy pulses, no start ever.
    ms_a = 8'h09; game_en_a = 1'b1;
    tick();
    attempt(1'b0, "limit1", hx);
    attempt(1'b0, "limit2", hx);
    game_en_a = 1'b0; ms_a = '0;
    tick();

    // MAX_ACTIVE=4, holes 0..2 busy: scan lands on hole 3; then all busy.
    ms_b = 8'h39; game_en_b = 1'b1;
    tick();
    attempt(1'b1, "scan", hb);
    check("scan_hole3", 32'(start_b), 32'(hot(3)));
    ms_b[7:6] = 2'b01;
    tick();
    check("scan_accept_drop", 32'(start_b), 32'd0);
    check("scan_accept_count", 32'(sp_b), 32'd1);
    attempt(1'b1, "all_busy", hx);
    game_en_b = 1'b0;
    tick();

    // Saturation of spawns_total.
    game_en_a = 1'b1; ms_a = '0;
    tick();
    exp_sp = 1;
    for (int n = 0; n < 300; n++) begin
      attempt(1'b0, "sat", h);
      if (h < 0) h = 0;
      ms_a[2*h +: 2] = 2'b01;
      tick();
      exp_sp = (exp_sp == 255) ? 255 : exp_sp + 1;
      check("sat_count", 32'(sp_a), 32'(exp_sp));
      ms_a = '0;
    end
    check("sat_final", 32'(sp_a), 32'd255);

    // Reset mid-HOLD with one other hole occupied.
    attempt(1'b0, "pre_reset", h);
    if (h < 0) h = 0;
    ms_a[2*((h + 1) % N) +: 2] = 2'b10;
    tick();
    check("pre_reset_active", 32'(act_a), 32'd1);
    rst = 1'b1;
    tick();
    check("midhold_rst_start", 32'(start_a), 32'd0);
    check("midhold_rst_active", 32'(act_a), 32'd0);
    check("midhold_rst_spawns", 32'(sp_a), 32'd0);
    check("midhold_rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0; game_en_a = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
